// File: rtl/tl_ul_pkg.sv
// TL-UL opcodes, payload widths and packed payload layouts shared by the buffer
// and by anything that builds or decodes beats.
package tl_ul_pkg;

  localparam logic [2:0] OP_PUT_FULL        = 3'd0;
  localparam logic [2:0] OP_PUT_PARTIAL     = 3'd1;
  localparam logic [2:0] OP_GET             = 3'd4;
  localparam logic [2:0] OP_ACCESS_ACK      = 3'd0;
  localparam logic [2:0] OP_ACCESS_ACK_DATA = 3'd1;

  localparam int SINK_W = 1;

  function automatic int a_width(input int addr_w, input int data_w,
                                 input int src_w, input int size_w);
    return 3 + 3 + size_w + src_w + addr_w + data_w / 8 + 1 + data_w;
  endfunction

  function automatic int d_width(input int data_w, input int src_w, input int size_w);
    return 3 + 2 + size_w + src_w + SINK_W + 1 + 1 + data_w;
  endfunction

  // Layouts for the default 32-bit address/data, 1-bit source, 2-bit size build.
  typedef struct packed {
    logic [2:0]  opcode;
    logic [2:0]  param;
    logic [1:0]  size;
    logic [0:0]  source;
    logic [31:0] address;
    logic [3:0]  mask;
    logic        corrupt;
    logic [31:0] data;
  } tl_a_t;

  typedef struct packed {
    logic [2:0]        opcode;
    logic [1:0]        param;
    logic [1:0]        size;
    logic [0:0]        source;
    logic [SINK_W-1:0] sink;
    logic              denied;
    logic              corrupt;
    logic [31:0]       data;
  } tl_d_t;

endpackage

// File: rtl/tl_ul_queue.sv
// Ready/valid circular queue with optional pipe (enqueue-when-full) and flow
// (empty bypass) behaviour; DEPTH=0 degenerates to wires.
module tl_ul_queue #(
  parameter int DEPTH = 2,
  parameter int W     = 8,
  parameter int PIPE  = 0,
  parameter int FLOW  = 0,
  localparam int CW   = (DEPTH < 1) ? 1 : $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          enq_valid,
  output logic          enq_ready,
  input  logic [W-1:0]  enq_bits,
  output logic          deq_valid,
  input  logic          deq_ready,
  output logic [W-1:0]  deq_bits,
  output logic [CW-1:0] count
);

  if (DEPTH == 0) begin : g_wire
    assign enq_ready = deq_ready;
    assign deq_valid = enq_valid;
    assign deq_bits  = enq_bits;
    assign count     = '0;
  end else begin : g_fifo
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] rd_ptr, wr_ptr;
    logic [CW-1:0] cnt;
    logic          empty, full, bypass, do_wr, do_rd;

    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign empty     = (cnt == '0);
    assign full      = (cnt == CW'(DEPTH));
    assign bypass    = (FLOW != 0) && empty;
    assign enq_ready = !full || ((PIPE != 0) && deq_ready);
    assign deq_valid = !empty || ((FLOW != 0) && enq_valid);
    assign deq_bits  = bypass ? enq_bits : mem[rd_ptr];
    // A bypassed beat that is consumed immediately never touches storage.
    assign do_wr     = enq_valid && enq_ready && !(bypass && deq_ready);
    assign do_rd     = deq_valid && deq_ready && !bypass;
    assign count     = cnt;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        cnt    <= '0;
        for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else begin
        if (do_wr) begin
          mem[wr_ptr] <= enq_bits;
          wr_ptr      <= nxt(wr_ptr);
        end
        if (do_rd) rd_ptr <= nxt(rd_ptr);
        if (do_wr && !do_rd)      cnt <= cnt + 1'b1;
        else if (do_rd && !do_wr) cnt <= cnt - 1'b1;
      end
    end
  end

endmodule

// File: rtl/tl_ul_buffer_param.sv
// TL-UL A/D buffer with per-channel queues and an outstanding-request throttle
// that also reports when the whole buffer is quiescent.
module tl_ul_buffer_param
  import tl_ul_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int SRC_W   = 1,
  parameter int SIZE_W  = 2,
  parameter int A_DEPTH = 2,
  parameter int D_DEPTH = 2,
  parameter int A_PIPE  = 0,
  parameter int D_PIPE  = 0,
  parameter int A_FLOW  = 0,
  parameter int D_FLOW  = 0,
  parameter int MAX_OUT = 4,
  localparam int A_W    = a_width(ADDR_W, DATA_W, SRC_W, SIZE_W),
  localparam int D_W    = d_width(DATA_W, SRC_W, SIZE_W),
  localparam int ACW    = (A_DEPTH < 1) ? 1 : $clog2(A_DEPTH + 1),
  localparam int DCW    = (D_DEPTH < 1) ? 1 : $clog2(D_DEPTH + 1),
  localparam int OW     = $clog2(MAX_OUT + 1)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           a_in_valid,
  output logic           a_in_ready,
  input  logic [A_W-1:0] a_in_bits,
  output logic           a_out_valid,
  input  logic           a_out_ready,
  output logic [A_W-1:0] a_out_bits,
  input  logic           d_in_valid,
  output logic           d_in_ready,
  input  logic [D_W-1:0] d_in_bits,
  output logic           d_out_valid,
  input  logic           d_out_ready,
  output logic [D_W-1:0] d_out_bits,
  output logic [ACW-1:0] a_count,
  output logic [DCW-1:0] d_count,
  output logic [OW-1:0]  outstanding,
  output logic           idle
);

  logic a_enq_ready, thr_ok, a_fire, d_fire;

  // A completing response frees a slot in the same cycle it is returned.
  assign d_fire     = d_out_valid && d_out_ready;
  assign thr_ok     = (outstanding < OW'(MAX_OUT)) || d_fire;
  assign a_in_ready = a_enq_ready && thr_ok;
  assign a_fire     = a_in_valid && a_in_ready;

  tl_ul_queue #(.DEPTH(A_DEPTH), .W(A_W), .PIPE(A_PIPE), .FLOW(A_FLOW)) u_a_queue (
    .clk       (clk),
    .rst_n     (rst_n),
    .enq_valid (a_in_valid && thr_ok),
    .enq_ready (a_enq_ready),
    .enq_bits  (a_in_bits),
    .deq_valid (a_out_valid),
    .deq_ready (a_out_ready),
    .deq_bits  (a_out_bits),
    .count     (a_count)
  );

  tl_ul_queue #(.DEPTH(D_DEPTH), .W(D_W), .PIPE(D_PIPE), .FLOW(D_FLOW)) u_d_queue (
    .clk       (clk),
    .rst_n     (rst_n),
    .enq_valid (d_in_valid),
    .enq_ready (d_in_ready),
    .enq_bits  (d_in_bits),
    .deq_valid (d_out_valid),
    .deq_ready (d_out_ready),
    .deq_bits  (d_out_bits),
    .count     (d_count)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      outstanding <= '0;
    end else if (a_fire && !d_fire) begin
      outstanding <= outstanding + 1'b1;
    end else if (d_fire && !a_fire && (outstanding != '0)) begin
      outstanding <= outstanding - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n) assert (!(d_fire && (outstanding == '0)))
      else $error("tl_ul_buffer_param: D beat returned with no outstanding request");
  end

  assign idle = (outstanding == '0) && (a_count == '0) && (d_count == '0);

endmodule
